// File: rtl/flash_stream_reader.sv
// Wishbone master that fetches flash bytes through a two-register slave
// (address register + byte data register) and streams little-endian 32-bit words.
module flash_stream_reader #(
  parameter logic [31:0] SLAVE_BASE = 32'h0000_0000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [22:0] cmd_addr,
  input  logic [15:0] cmd_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        done,
  output logic        error,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  input  logic        m_stall_i
);

  localparam logic [31:0] ADR_REG  = SLAVE_BASE | 32'h1;
  localparam logic [31:0] DAT_REG  = SLAVE_BASE;
  localparam int          TMO_LAST = TIMEOUT - 1;

  typedef enum logic [2:0] {
    IDLE, ADR_REQ, ADR_WAIT, DAT_REQ, DAT_WAIT, EMIT, FINISH
  } state_t;

  state_t      state;
  logic [22:0] byte_addr;
  logic [22:0] next_addr;
  logic [15:0] words_left;
  logic [1:0]  byte_idx;
  logic [23:0] lanes;
  logic [31:0] tmo_cnt;
  logic        is_req;
  logic        is_adr;
  logic        resp_valid;
  logic        resp_ok;
  logic        resp_fail;
  logic        req_taken;
  logic        tmo_hit;
  logic        unused_dat;

  assign m_sel_o    = 4'b1111;
  assign unused_dat = ^m_dat_i[31:8];
  assign next_addr  = byte_addr + 23'd1;

  // A response only counts in a request state once the strobe is accepted;
  // ack together with err/rty is treated as a failure.
  always_comb begin
    is_req     = (state == ADR_REQ) || (state == DAT_REQ);
    is_adr     = (state == ADR_REQ) || (state == ADR_WAIT);
    resp_valid = is_req ? !m_stall_i : 1'b1;
    resp_fail  = resp_valid && (m_err_i || m_rty_i);
    resp_ok    = resp_valid && m_ack_i && !(m_err_i || m_rty_i);
    req_taken  = is_req && !m_stall_i;
    tmo_hit    = (tmo_cnt == 32'(TMO_LAST));
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_bus) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            byte_addr  <= cmd_addr;
            words_left <= cmd_len;
            byte_idx   <= 2'd0;
            error      <= 1'b0;
            cmd_ready  <= 1'b0;
            tmo_cnt    <= '0;
            if (cmd_len == 16'd0) begin
              state <= FINISH;
            end else begin
              state   <= ADR_REQ;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= 1'b1;
              m_adr_o <= ADR_REG;
              m_dat_o <= {9'b0, cmd_addr};
            end
          end
        end

        ADR_REQ, ADR_WAIT, DAT_REQ, DAT_WAIT: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (resp_fail || (tmo_hit && !resp_ok)) begin
            error   <= 1'b1;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            tmo_cnt <= '0;
            state   <= FINISH;
          end else if (resp_ok && is_adr) begin
            tmo_cnt <= '0;
            state   <= DAT_REQ;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b0;
            m_adr_o <= DAT_REG;
          end else if (resp_ok) begin
            tmo_cnt   <= '0;
            byte_addr <= next_addr;
            byte_idx  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state     <= EMIT;
              m_cyc_o   <= 1'b0;
              m_stb_o   <= 1'b0;
              m_we_o    <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= {m_dat_i[7:0], lanes};
            end else begin
              case (byte_idx)
                2'd0:    lanes[7:0]   <= m_dat_i[7:0];
                2'd1:    lanes[15:8]  <= m_dat_i[7:0];
                default: lanes[23:16] <= m_dat_i[7:0];
              endcase
              state   <= ADR_REQ;
              m_stb_o <= 1'b1;
              m_we_o  <= 1'b1;
              m_adr_o <= ADR_REG;
              m_dat_o <= {9'b0, next_addr};
            end
          end else if (req_taken) begin
            tmo_cnt <= '0;
            m_stb_o <= 1'b0;
            if (state == ADR_REQ) state <= ADR_WAIT;
            else                  state <= DAT_WAIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            words_left <= words_left - 16'd1;
            if (words_left == 16'd1) begin
              state <= FINISH;
            end else begin
              state   <= ADR_REQ;
              tmo_cnt <= '0;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= 1'b1;
              m_adr_o <= ADR_REG;
              m_dat_o <= {9'b0, byte_addr};
            end
          end
        end

        FINISH: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
